// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Frame: A5, LEN_LO, LEN_HI, N little-endian words, XOR checksum.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam int         LEN_W        = 16;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on clr or while idle, fires expire
// once TIMEOUT_CYCLES enabled cycles pass without a clr.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign expire = en && !clr && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image over UART, writes it into
// instruction memory and holds/restarts the core around the load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              core_hold,
  output logic              core_restart,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  loader_state_e state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              restart_q, restart_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  len_full;
  logic              tmo_en;
  logic              tmo_expire;

  assign tmo_en = (state_q == ST_LEN_LO) ||
                  (state_q == ST_LEN_HI) ||
                  (state_q == ST_DATA)   ||
                  (state_q == ST_CHECK);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rx_valid),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    restart_d = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    len_full  = {rx_data, len_q[7:0]};

    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (rx_data == LOADER_MAGIC) begin
            state_d = ST_LEN_LO;
            busy_d  = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            csum_d  = '0;
            idx_d   = '0;
            bcnt_d  = '0;
            len_d   = '0;
          end
        end
        ST_LEN_LO: begin
          len_d   = {8'h00, rx_data};
          csum_d  = csum_q ^ rx_data;
          state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d  = len_full;
          csum_d = csum_q ^ rx_data;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (len_full == '0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          csum_d = csum_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q[ADDR_W-1:0];
            wr_data_d = {rx_data, word_q};
            idx_d     = idx_q + LEN_W'(1);
            if (idx_q == len_q - LEN_W'(1)) begin
              state_d = ST_CHECK;
            end
          end else begin
            // Shift in from the top so byte 0 lands in [7:0].
            word_d = {rx_data, word_q[23:8]};
          end
        end
        ST_CHECK: begin
          if (rx_data == csum_q) begin
            state_d   = ST_DONE;
            restart_d = 1'b1;
            hold_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (tmo_expire) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign core_hold    = hold_q;
  assign core_restart = restart_q;
  assign busy         = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule
